// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with glitch filter, parity/stop/timeout checks and FWFT FIFO.
module ps2_rx_fifo #(
  parameter int FILT_LEN   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 5000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ps2_c,
  input  logic                                ps2_d,
  input  logic                                tx_idle,
  input  logic                                rd_en,
  input  logic                                clr_ovf,
  output logic [7:0]                          dout,
  output logic                                empty,
  output logic                                full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count,
  output logic                                rx_done,
  output logic                                parity_err,
  output logic                                frame_err,
  output logic                                overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
  logic [1:0] cs_q, ds_q;
  logic [FILT_LEN-1:0] filt_q;
  logic fclk_q, fall_q, all0, all1, d;
  logic [1:0] st_q, st_d;
  logic [2:0] bc_q, bc_d;
  logic [7:0] sh_q, sh_d;
  logic par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic done_q, perr_q, ferr_q, ovf_q;
  logic push, pop, perr_d, ferr_d, ovf_set;
  assign d     = ds_q[1];
  assign all0  = filt_q == '0;
  assign all1  = &filt_q;
  assign empty = cnt_q == '0;
  assign full  = cnt_q == CW'(FIFO_DEPTH);
  assign count = cnt_q;
  assign dout  = empty ? 8'h00 : mem[rp_q];
  assign pop   = rd_en && !empty;
  assign rx_done    = done_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;
  always_comb begin
    st_d = st_q;
    bc_d = bc_q;
    sh_d = sh_q;
    par_d = par_q;
    push = 1'b0;
    perr_d = 1'b0;
    ferr_d = 1'b0;
    ovf_set = 1'b0;
    to_d = (st_q == IDLE || fall_q) ? '0 : to_q + 1'b1;
    if (st_q != IDLE && !tx_idle) st_d = IDLE;
    else if (st_q != IDLE && !fall_q && to_q == TW'(TIMEOUT-1)) begin
      st_d = IDLE;
      ferr_d = 1'b1;
    end else if (fall_q)
      case (st_q)
        IDLE: if (!d && tx_idle) begin
          st_d = DATA;
          bc_d = 3'd0;
          sh_d = 8'h00;
        end
        DATA: begin
          sh_d = {d, sh_q[7:1]};
          bc_d = bc_q + 3'd1;
          st_d = bc_q == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          par_d = d;
          st_d = STOP;
        end
        default: begin
          st_d = IDLE;
          // odd parity: data plus parity bit must carry an odd number of ones
          if (!d) ferr_d = 1'b1;
          else if (!(^{sh_q, par_q})) perr_d = 1'b1;
          else if (full && !pop) ovf_set = 1'b1;
          else push = 1'b1;
        end
      endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      cs_q <= 2'b11;
      ds_q <= 2'b11;
      filt_q <= '1;
      fclk_q <= 1'b1;
      fall_q <= 1'b0;
      st_q <= IDLE;
      bc_q <= 3'd0;
      sh_q <= 8'h00;
      par_q <= 1'b0;
      to_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cs_q <= {cs_q[0], ps2_c};
      ds_q <= {ds_q[0], ps2_d};
      filt_q <= {filt_q[FILT_LEN-2:0], cs_q[1]};
      fclk_q <= all0 ? 1'b0 : all1 ? 1'b1 : fclk_q;
      fall_q <= fclk_q && all0;
      st_q <= st_d;
      bc_q <= bc_d;
      sh_q <= sh_d;
      par_q <= par_d;
      to_q <= to_d;
      wp_q <= wp_q + AW'(push);
      rp_q <= rp_q + AW'(pop);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      done_q <= push;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      ovf_q <= ovf_set || (ovf_q && !clr_ovf);
    end
  end
  always_ff @(posedge clk) if (push) mem[wp_q] <= sh_q;
endmodule
